// File: rtl/management_wishbone_bridge_if.sv
// Wishbone classic master bus bundle used by the management bridge.
//   master modport : drives cyc/stb/we/sel/adr/dat_o, receives dat_i/ack/err
//   slave modport  : the mirror view for a Wishbone target (or a bench)
// Signal names keep the Wishbone _o/_i suffixes as seen from the master.
interface management_wishbone_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/management_wishbone_bridge.sv
// Bridge from the single-cycle JTAG management request port to a Wishbone
// classic master. One transaction is outstanding at a time; requests that
// arrive while busy are dropped and flagged as overrun.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   mgmt_enable       : request strobe; writeEnable/byteSelect/address/
//                       writeData are sampled with it
//   mgmt_readData     : last read result (0xFFFF_FFFF on error/timeout)
//   mgmt_readValid    : one-cycle pulse when mgmt_readData updates
//   mgmt_busy         : request latched / Wishbone cycle open
//   mgmt_status       : sticky {overrun, busError}; mgmt_statusClear clears
//   wb                : Wishbone master bundle
module management_wishbone_bridge #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mgmt_enable,
  input  logic        mgmt_writeEnable,
  input  logic [3:0]  mgmt_byteSelect,
  input  logic [19:0] mgmt_address,
  input  logic [31:0] mgmt_writeData,
  output logic [31:0] mgmt_readData,
  output logic        mgmt_readValid,
  output logic        mgmt_busy,
  output logic [1:0]  mgmt_status,
  input  logic        mgmt_statusClear,
  management_wishbone_bridge_if.master wb
);

  // The counter holds the number of BUS cycles already completed, so the
  // limit is reached at the closing edge of the cycle where it equals N-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state;
  logic [7:0]  cycleCount;
  logic        cycReg;
  logic        weReg;
  logic [3:0]  selReg;
  logic [31:0] adrReg;
  logic [31:0] datReg;

  logic        timeoutHit;
  logic        termDone;
  logic        termFail;
  logic        setOverrun;
  logic        setBusError;
  logic [1:0]  statusNext;

  // An all-zero lane mask would select nothing; treat it as a full word.
  function automatic logic [3:0] laneMask(input logic [3:0] sel);
    return (sel == 4'h0) ? 4'hF : sel;
  endfunction

  function automatic logic [31:0] busAddress(input logic [19:0] wordAddr);
    return {BASE_ADDRESS[31:22], wordAddr, 2'b00};
  endfunction

  always_comb begin
    timeoutHit  = (cycleCount == TIMEOUT_LAST);
    // Ack or err in the timeout cycle wins over the timeout itself.
    termDone    = wb.wb_ack_i || wb.wb_err_i || timeoutHit;
    termFail    = wb.wb_err_i || (!wb.wb_ack_i && timeoutHit);
    setOverrun  = (state == BUS) && mgmt_enable;
    setBusError = (state == BUS) && termFail;
    // Set beats clear when both happen in the same cycle.
    statusNext  = mgmt_statusClear ? 2'b00 : mgmt_status;
    statusNext  = statusNext | {setOverrun, setBusError};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cycleCount     <= 8'd0;
      cycReg         <= 1'b0;
      weReg          <= 1'b0;
      selReg         <= 4'h0;
      adrReg         <= 32'h0;
      datReg         <= 32'h0;
      mgmt_readData  <= 32'h0;
      mgmt_readValid <= 1'b0;
      mgmt_status    <= 2'b00;
    end else begin
      mgmt_readValid <= 1'b0;
      mgmt_status    <= statusNext;
      unique case (state)
        IDLE: begin
          if (mgmt_enable) begin
            state      <= BUS;
            cycleCount <= 8'd0;
            cycReg     <= 1'b1;
            weReg      <= mgmt_writeEnable;
            selReg     <= laneMask(mgmt_byteSelect);
            adrReg     <= busAddress(mgmt_address);
            datReg     <= mgmt_writeEnable ? mgmt_writeData : 32'h0;
          end
        end
        BUS: begin
          if (termDone) begin
            state      <= IDLE;
            cycleCount <= 8'd0;
            cycReg     <= 1'b0;
            weReg      <= 1'b0;
            selReg     <= 4'h0;
            adrReg     <= 32'h0;
            datReg     <= 32'h0;
            if (!weReg) begin
              mgmt_readValid <= 1'b1;
              mgmt_readData  <= termFail ? 32'hFFFF_FFFF : wb.wb_dat_i;
            end
          end else begin
            cycleCount <= cycleCount + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.wb_cyc_o = cycReg;
  assign wb.wb_stb_o = cycReg;
  assign wb.wb_we_o  = weReg;
  assign wb.wb_sel_o = selReg;
  assign wb.wb_adr_o = adrReg;
  assign wb.wb_dat_o = datReg;
  assign mgmt_busy   = cycReg;

endmodule

// File: tb/tb_management_wishbone_bridge.sv
// Self-checking bench for management_wishbone_bridge: a transaction-level
// reference model predicts every output each cycle; directed scenarios add
// literal expectations. A second instance with a short timeout and a silent
// slave covers the 4-cycle timeout case.
module tb_management_wishbone_bridge;
  localparam int          TO_MAIN  = 6;
  localparam int          TO_SHORT = 4;
  localparam logic [31:0] BASE     = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mgmt_enable;
  logic        mgmt_writeEnable;
  logic [3:0]  mgmt_byteSelect;
  logic [19:0] mgmt_address;
  logic [31:0] mgmt_writeData;
  logic        mgmt_statusClear;

  logic [31:0] rd1, rd2;
  logic        rv1, rv2, busy1, busy2;
  logic [1:0]  st1, st2;

  always #5 clk = ~clk;

  management_wishbone_bridge_if wb1 ();
  management_wishbone_bridge_if wb2 ();

  management_wishbone_bridge #(.BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .rst(rst),
    .mgmt_enable(mgmt_enable), .mgmt_writeEnable(mgmt_writeEnable),
    .mgmt_byteSelect(mgmt_byteSelect), .mgmt_address(mgmt_address),
    .mgmt_writeData(mgmt_writeData), .mgmt_readData(rd1),
    .mgmt_readValid(rv1), .mgmt_busy(busy1), .mgmt_status(st1),
    .mgmt_statusClear(mgmt_statusClear), .wb(wb1)
  );

  management_wishbone_bridge #(.BASE_ADDRESS(BASE), .TIMEOUT_CYCLES(TO_SHORT)) dutShort (
    .clk(clk), .rst(rst),
    .mgmt_enable(mgmt_enable), .mgmt_writeEnable(mgmt_writeEnable),
    .mgmt_byteSelect(mgmt_byteSelect), .mgmt_address(mgmt_address),
    .mgmt_writeData(mgmt_writeData), .mgmt_readData(rd2),
    .mgmt_readValid(rv2), .mgmt_busy(busy2), .mgmt_status(st2),
    .mgmt_statusClear(mgmt_statusClear), .wb(wb2)
  );

  // ---------------- reference model (transaction level) ----------------
  logic        mBusy = 1'b0;
  int          mElapsed = 0;
  logic        mWe = 1'b0;
  logic [3:0]  mSel = 4'h0;
  logic [19:0] mAddr = 20'h0;
  logic [31:0] mData = 32'h0;
  logic [31:0] mReadData = 32'h0;
  logic        mReadValid = 1'b0;
  logic [1:0]  mStatus = 2'b00;

  always @(posedge clk) begin : model
    logic ovr, berr, fail;
    ovr = 1'b0; berr = 1'b0; fail = 1'b0;
    if (rst) begin
      mBusy = 1'b0; mElapsed = 0; mWe = 1'b0; mSel = 4'h0; mAddr = 20'h0;
      mData = 32'h0; mReadData = 32'h0; mReadValid = 1'b0; mStatus = 2'b00;
    end else begin
      mReadValid = 1'b0;
      if (mBusy) begin
        ovr = mgmt_enable;
        mElapsed = mElapsed + 1;
        if (wb1.wb_ack_i || wb1.wb_err_i || mElapsed >= TO_MAIN) begin
          fail = wb1.wb_err_i || !wb1.wb_ack_i;
          berr = fail;
          if (!mWe) begin
            mReadValid = 1'b1;
            mReadData  = fail ? 32'hFFFF_FFFF : wb1.wb_dat_i;
          end
          mBusy = 1'b0;
        end
      end else if (mgmt_enable) begin
        mBusy = 1'b1; mElapsed = 0; mWe = mgmt_writeEnable;
        mSel = mgmt_byteSelect; mAddr = mgmt_address; mData = mgmt_writeData;
      end
      if (mgmt_statusClear) mStatus = 2'b00;
      mStatus = mStatus | {ovr, berr};
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    logic [31:0] eAdr, eDat;
    logic [3:0]  eSel;
    eAdr = mBusy ? {BASE[31:22], mAddr, 2'b00} : 32'h0;
    eSel = mBusy ? ((mSel == 4'h0) ? 4'hF : mSel) : 4'h0;
    eDat = (mBusy && mWe) ? mData : 32'h0;
    check("cyc",       32'(wb1.wb_cyc_o), 32'(mBusy));
    check("stb",       32'(wb1.wb_stb_o), 32'(mBusy));
    check("busy",      32'(busy1),        32'(mBusy));
    check("we",        32'(wb1.wb_we_o),  32'(mBusy && mWe));
    check("sel",       32'(wb1.wb_sel_o), 32'(eSel));
    check("adr",       wb1.wb_adr_o,      eAdr);
    check("datOut",    wb1.wb_dat_o,      eDat);
    check("readData",  rd1,               mReadData);
    check("readValid", 32'(rv1),          32'(mReadValid));
    check("status",    32'(st1),          32'(mStatus));
  endtask

  // Running totals observed each cycle; directed checks use deltas.
  int          cyc1Cnt = 0, rise1Cnt = 0, rv1Cnt = 0, busy1Cnt = 0;
  int          cyc2Cnt = 0, rv2Cnt = 0;
  logic        prevCyc1 = 1'b0;
  logic [31:0] lastAdr1 = 32'h0, lastDat1 = 32'h0;
  logic [3:0]  lastSel1 = 4'h0;

  // One clock: compare and observe at the falling edge, then return just
  // after the next rising edge so new inputs never race the DUT.
  task automatic tick();
    @(negedge clk);
    compareAll();
    cyc1Cnt  += int'(wb1.wb_cyc_o);
    busy1Cnt += int'(busy1);
    rv1Cnt   += int'(rv1);
    cyc2Cnt  += int'(wb2.wb_cyc_o);
    rv2Cnt   += int'(rv2);
    if (wb1.wb_cyc_o && !prevCyc1) rise1Cnt++;
    prevCyc1 = wb1.wb_cyc_o;
    if (wb1.wb_cyc_o) begin
      lastAdr1 = wb1.wb_adr_o; lastSel1 = wb1.wb_sel_o; lastDat1 = wb1.wb_dat_o;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [19:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
    mgmt_enable = 1'b1; mgmt_writeEnable = we; mgmt_address = addr;
    mgmt_byteSelect = sel; mgmt_writeData = data;
  endtask

  int s0, s1, s2, s3, s4;

  initial begin
    rst = 1'b1; mgmt_enable = 1'b0; mgmt_writeEnable = 1'b0;
    mgmt_byteSelect = 4'h0; mgmt_address = 20'h0; mgmt_writeData = 32'h0;
    mgmt_statusClear = 1'b0;
    wb1.wb_ack_i = 1'b0; wb1.wb_err_i = 1'b0; wb1.wb_dat_i = 32'h0;
    wb2.wb_ack_i = 1'b0; wb2.wb_err_i = 1'b0; wb2.wb_dat_i = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset readData", rd1, 32'h0);
    check("reset busy", 32'(busy1), 32'h0);
    check("reset status", 32'(st1), 32'h0);
    check("reset adr", wb1.wb_adr_o, 32'h0);

    // Timeout: silent slave, short instance ends after 4 BUS cycles.
    s0 = cyc2Cnt; s1 = rv2Cnt; s2 = cyc1Cnt;
    request(1'b0, 20'h00ABC, 4'h0, 32'h0);
    tick();
    mgmt_enable = 1'b0;
    repeat (8) tick();
    check("timeout cyc cycles", 32'(cyc2Cnt - s0), 32'd4);
    check("timeout readValid pulses", 32'(rv2Cnt - s1), 32'd1);
    check("timeout readData", rd2, 32'hFFFF_FFFF);
    check("timeout status", 32'(st2), 32'h1);
    check("timeout main cyc cycles", 32'(cyc1Cnt - s2), 32'd6);
    check("model timeout status", 32'(mStatus), 32'h1);
    mgmt_statusClear = 1'b1;
    tick();
    mgmt_statusClear = 1'b0;
    tick();
    check("status cleared", 32'(st1), 32'h0);

    // Read with ack in the fifth BUS cycle.
    s0 = rv1Cnt; s1 = busy1Cnt;
    request(1'b0, 20'h00010, 4'h0, 32'h0);
    tick();
    mgmt_enable = 1'b0;
    repeat (4) tick();
    wb1.wb_ack_i = 1'b1; wb1.wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb1.wb_ack_i = 1'b0; wb1.wb_dat_i = 32'h0;
    tick(); tick();
    check("read adr", lastAdr1, 32'h3000_0040);
    check("read sel", 32'(lastSel1), 32'hF);
    check("read data", rd1, 32'hCAFE_F00D);
    check("model read data", mReadData, 32'hCAFE_F00D);
    check("read pulses", 32'(rv1Cnt - s0), 32'd1);
    check("read busy cycles", 32'(busy1Cnt - s1), 32'd5);

    // Write with immediate ack.
    s0 = rv1Cnt; s1 = rise1Cnt;
    request(1'b1, 20'h00123, 4'h3, 32'h1234_5678);
    tick();
    mgmt_enable = 1'b0; wb1.wb_ack_i = 1'b1;
    tick();
    wb1.wb_ack_i = 1'b0;
    tick(); tick();
    check("write cycles", 32'(rise1Cnt - s1), 32'd1);
    check("write datOut", lastDat1, 32'h1234_5678);
    check("write sel", 32'(lastSel1), 32'h3);
    check("write pulses", 32'(rv1Cnt - s0), 32'd0);
    check("write status", 32'(st1), 32'h0);

    // Overrun: enable held into the first BUS cycle.
    s0 = rise1Cnt;
    request(1'b0, 20'h00005, 4'h1, 32'h0);
    tick();
    tick();
    mgmt_enable = 1'b0; wb1.wb_ack_i = 1'b1; wb1.wb_dat_i = 32'h0BAD_BEEF;
    tick();
    wb1.wb_ack_i = 1'b0;
    tick(); tick();
    check("overrun cycles", 32'(rise1Cnt - s0), 32'd1);
    check("overrun status", 32'(st1), 32'h2);
    mgmt_statusClear = 1'b1;
    tick();
    mgmt_statusClear = 1'b0;
    tick();
    check("overrun cleared", 32'(st1), 32'h0);

    // Error together with ack.
    request(1'b0, 20'h00777, 4'hF, 32'h0);
    tick();
    mgmt_enable = 1'b0; wb1.wb_ack_i = 1'b1; wb1.wb_err_i = 1'b1;
    wb1.wb_dat_i = 32'h0000_0055;
    tick();
    wb1.wb_ack_i = 1'b0; wb1.wb_err_i = 1'b0;
    tick();
    check("error readData", rd1, 32'hFFFF_FFFF);
    check("error status", 32'(st1), 32'h1);

    // Reset in the middle of a read, ack afterwards.
    request(1'b0, 20'h00042, 4'h0, 32'h0);
    tick();
    mgmt_enable = 1'b0;
    tick();
    s0 = rv1Cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset cyc after edge", 32'(wb1.wb_cyc_o), 32'h0);
    wb1.wb_ack_i = 1'b1; wb1.wb_dat_i = 32'hAAAA_AAAA;
    tick();
    wb1.wb_ack_i = 1'b0;
    tick();
    check("midreset pulses", 32'(rv1Cnt - s0), 32'd0);
    check("midreset readData", rd1, 32'h0);
    check("midreset status", 32'(st1), 32'h0);
    check("midreset busy", 32'(busy1), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 299) == 0);
      mgmt_enable      = ($urandom_range(0, 5) == 0);
      mgmt_writeEnable = $urandom_range(0, 1) != 0;
      mgmt_byteSelect  = 4'($urandom_range(0, 15));
      mgmt_address     = 20'($urandom);
      mgmt_writeData   = $urandom;
      mgmt_statusClear = ($urandom_range(0, 39) == 0);
      wb1.wb_ack_i     = ($urandom_range(0, 4) == 0);
      wb1.wb_err_i     = ($urandom_range(0, 11) == 0);
      wb1.wb_dat_i     = $urandom;
      tick();
    end
    rst = 1'b0; mgmt_enable = 1'b0; mgmt_statusClear = 1'b0;
    wb1.wb_ack_i = 1'b0; wb1.wb_err_i = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
